serial_word_collector: RTL and testbench
========================================

// Module: serial_word_collector
// PURPOSE
//   Serial-to-parallel collector that sits directly downstream of simple_shifter.
//   Consumes the bit stream on the shifter's serial_out and reassembles WIDTH-bit words.
//   Supports MSB-first and LSB-first order, and frame alignment.
//   Presents each completed word on a one-entry valid/ready output register.
//   Flags any word lost to back-pressure in a sticky overflow bit.
// PARAMETERS
//   WIDTH  8  word width in bits; must be >= 2
//   CNT_W  (localparam) = $clog2(WIDTH); width of bit_count
// PORTS
//   clk          in   1      single clock; all logic on posedge clk
//   rst_n        in   1      synchronous, active-low reset
//   bit_in       in   1      serial data bit
//   bit_valid    in   1      bit_in is accepted this cycle when 1
//   msb_first    in   1      1 = first bit of word is MSB; 0 = first bit is LSB
//   frame_start  in   1      aligns the word boundary; discards any partial word
//   word_out     out  WIDTH  assembled word; stable while word_valid=1
//   word_valid   out  1      word_out holds an unconsumed word
//   word_ready   in   1      consumer accepts word_out when word_valid & word_ready
//   bit_count    out  CNT_W  bits collected toward the current word (0..WIDTH-1)
//   busy         out  1      bit_count != 0 (partial word held)
//   overflow     out  1      sticky: a completed word was dropped
//   overflow_clr in   1      clears overflow
// BEHAVIOUR
// - Reset (rst_n=0 at posedge clk): clears collect reg, bit_count, word_out, word_valid and overflow to 0.
//   Reset overrides every other input, including in the middle of a word.
// - Bit order (order_q):
//   - Latched from msb_first when a bit is accepted with bit_count==0.
//   - That first bit itself uses msb_first directly.
//   - Changes to msb_first mid-word are ignored until the next word.
// - Bit accept, with bit_valid=1:
//   - order 1: col <= {col[WIDTH-2:0], bit_in} (left shift in; matches shifter shift_dir=0).
//   - order 0: col <= {bit_in, col[WIDTH-1:1]} (right shift in; matches shifter shift_dir=1).
//   - bit_count increments and wraps WIDTH-1 -> 0.
// - bit_valid=0: col and bit_count hold. Gaps of any length are legal.
// - Word completion: a bit is accepted while bit_count==WIDTH-1. The completed word includes that bit.
//   - Output free (word_valid=0, or word_valid & word_ready this cycle):
//     next cycle word_out = completed word and word_valid = 1.
//   - Otherwise: the completed word is dropped; word_out and word_valid are unchanged; overflow <= 1.
//   - In both cases bit_count -> 0 and col is don't-care.
// - Latency: word_valid rises 1 cycle after the last bit is accepted.
//   Back-to-back words at 1 bit/clk with word_ready=1 need no stall.
// - Output handshake:
//   - While word_valid=1 and word_ready=0, word_out and word_valid hold.
//   - On word_valid & word_ready with no completion that cycle, word_valid -> 0 next cycle and word_out holds its value.
// - frame_start=1: bit_count <= 0 and col <= 0, discarding the partial word; overflow is not set.
//   - With bit_valid=1 in the same cycle, bit_in becomes the first bit of the new word: bit_count -> 1, order latched.
//   - frame_start takes priority over completion: no word is emitted that cycle.
//   - The output register and its handshake are unaffected.
// - overflow: set has priority over overflow_clr in the same cycle. Otherwise overflow_clr=1 clears it next cycle.
// - busy and bit_count are registered values and carry no combinational input paths.
// TESTING (WIDTH=8)
// 1. Reset; msb_first=1, ready=1; feed 1,0,1,0,0,1,0,1 on consecutive cycles
//    -> word_out=8'hA5; word_valid high exactly 1 cycle, 1 clk after the 8th bit.
// 2. msb_first=0; feed 1,0,1,0,0,1,0,1; flip msb_first after the 2nd bit
//    -> word_out=8'hA5 (order latched at first bit).
// 3. ready=0; send 8'h3C then 8'h5A
//    -> word_out stays 8'h3C, overflow=1 after 16th bit; overflow_clr=1 -> overflow=0; ready=1 -> 8'h3C consumed once.
// 4. word_valid=1 holding 8'h11; ready=1 in the same cycle as the last bit of 8'h22
//    -> next cycle word_out=8'h22, word_valid=1, overflow=0.
// 5. Feed 3 bits, then frame_start with bit_valid=1 -> bit_count=1; 7 more bits form the word;
//    frame_start alone -> bit_count=0, busy=0.
// 6. Feed 8'hC3 with random bit_valid gaps -> 8'hC3; rst_n=0 after 5 bits of the next word
//    -> all outputs 0 next cycle, next word assembles cleanly.

Source files
------------

// File: rtl/serial_word_collector.sv
// Purpose : serial-to-parallel word collector fed by simple_shifter's serial_out (MSB- or LSB-first, frame aligned).
// Latency : word_valid rises 1 clk after the last bit of a word is accepted; 1 bit/clk sustained with word_ready=1.
// Backpres: one-entry output register; a word completing while that register is full is dropped and sets sticky overflow.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   bit_in, bit_valid          serial bit and its qualifier
//   msb_first                  order for the next word (latched on its first bit)
//   frame_start                discard partial word, realign word boundary
//   word_out, word_valid,      assembled word with valid/ready handshake
//   word_ready
//   bit_count, busy            registered progress through the current word
//   overflow, overflow_clr     sticky dropped-word flag and its clear
module serial_word_collector #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       msb_first,
  input  logic                       frame_start,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH)-1:0]   bit_count,
  output logic                       busy,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_col;
  logic [CNT_W-1:0] r_cnt;
  logic             r_order;
  logic [WIDTH-1:0] r_word;
  logic             r_vld;
  logic             r_ovf;

  logic             w_order;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_fs_col;
  logic             w_last;
  logic             w_complete;
  logic             w_free;
  logic [CNT_W-1:0] w_cnt_inc;

  always_comb begin
    // The first bit of a word follows msb_first directly; later bits use the latched order.
    w_order    = (r_cnt == '0) ? msb_first : r_order;
    w_shift    = w_order ? {r_col[WIDTH-2:0], bit_in} : {bit_in, r_col[WIDTH-1:1]};
    // A bit arriving with frame_start starts a fresh word from an all-zero collector.
    w_fs_col   = msb_first ? {{(WIDTH-1){1'b0}}, bit_in} : {bit_in, {(WIDTH-1){1'b0}}};
    w_last     = (r_cnt == CNT_W'(WIDTH-1));
    w_complete = bit_valid && !frame_start && w_last;
    // Output register can take a new word if empty or being drained this cycle.
    w_free     = !r_vld || word_ready;
    w_cnt_inc  = w_last ? '0 : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_cnt   <= '0;
      r_order <= 1'b0;
      r_word  <= '0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (frame_start) begin
        if (bit_valid) begin
          r_col   <= w_fs_col;
          r_cnt   <= CNT_W'(1);
          r_order <= msb_first;
        end else begin
          r_col <= '0;
          r_cnt <= '0;
        end
      end else if (bit_valid) begin
        r_col <= w_shift;
        r_cnt <= w_cnt_inc;
        if (r_cnt == '0) begin
          r_order <= msb_first;
        end
      end

      if (w_complete && w_free) begin
        r_word <= w_shift;
        r_vld  <= 1'b1;
      end else if (r_vld && word_ready) begin
        r_vld <= 1'b0;
      end

      // Setting wins over clearing when both happen in one cycle.
      if (w_complete && !w_free) begin
        r_ovf <= 1'b1;
      end else if (overflow_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_vld;
  assign bit_count  = r_cnt;
  assign busy       = (r_cnt != '0);
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       msb_first;
  logic       frame_start;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic [2:0] bit_count;
  logic       busy;
  logic       overflow;
  logic       overflow_clr;

  int vectors = 0;
  int miscompares = 0;

  serial_word_collector #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .msb_first    (msb_first),
    .frame_start  (frame_start),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .bit_count    (bit_count),
    .busy         (busy),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send bits lo..hi of word w in transmit order (ord=1: w[7] first; ord=0: w[0] first).
  task automatic send_range(input logic [7:0] w, input bit ord, input int lo, input int hi,
                            input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        bit_valid = 1'b0;
        for (int k = 0; k < g; k++) tick();
      end
      bit_in    = ord ? w[7-i] : w[i];
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; msb_first = 1'b1;
    frame_start = 1'b0; word_ready = 1'b1; overflow_clr = 1'b0;
    tick();
    chk("rst_word_out", word_out, 8'h00);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    // 1: MSB-first A5, back-to-back bits
    msb_first = 1'b1;
    send_range(8'hA5, 1'b1, 0, 6, 1'b0);
    chk("t1_count7", bit_count, 7);
    chk("t1_busy", busy, 1);
    chk("t1_not_valid_yet", word_valid, 0);
    send_range(8'hA5, 1'b1, 7, 7, 1'b0);
    chk("t1_valid", word_valid, 1);
    chk("t1_word", word_out, 8'hA5);
    chk("t1_count_wrap", bit_count, 0);
    tick();
    chk("t1_valid_one_cycle", word_valid, 0);
    chk("t1_word_held", word_out, 8'hA5);

    // 2: LSB-first; msb_first flips after the 2nd bit and must be ignored
    msb_first = 1'b0;
    send_range(8'hA5, 1'b0, 0, 1, 1'b0);
    msb_first = 1'b1;
    send_range(8'hA5, 1'b0, 2, 7, 1'b0);
    chk("t2_valid", word_valid, 1);
    chk("t2_word", word_out, 8'hA5);
    tick();
    chk("t2_drain", word_valid, 0);

    // 3: back-pressure, 3C held, 5A dropped
    msb_first = 1'b1; word_ready = 1'b0;
    send_range(8'h3C, 1'b1, 0, 7, 1'b0);
    chk("t3_valid_3c", word_valid, 1);
    chk("t3_word_3c", word_out, 8'h3C);
    send_range(8'h5A, 1'b1, 0, 6, 1'b0);
    chk("t3_no_ovf_yet", overflow, 0);
    send_range(8'h5A, 1'b1, 7, 7, 1'b0);
    chk("t3_overflow", overflow, 1);
    chk("t3_word_kept", word_out, 8'h3C);
    chk("t3_valid_kept", word_valid, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    chk("t3_still_valid", word_valid, 1);
    word_ready = 1'b1;
    tick();
    chk("t3_consumed", word_valid, 0);
    tick();
    chk("t3_consumed_once", word_valid, 0);
    chk("t3_word_after", word_out, 8'h3C);

    // 4: 11 held, ready rises on the last bit of 22
    word_ready = 1'b0;
    send_range(8'h11, 1'b1, 0, 7, 1'b0);
    chk("t4_hold_11", word_out, 8'h11);
    send_range(8'h22, 1'b1, 0, 6, 1'b0);
    word_ready = 1'b1;
    send_range(8'h22, 1'b1, 7, 7, 1'b0);
    chk("t4_word_22", word_out, 8'h22);
    chk("t4_valid", word_valid, 1);
    chk("t4_no_ovf", overflow, 0);
    tick();
    chk("t4_drain", word_valid, 0);

    // 5: frame alignment
    send_range(8'hE0, 1'b1, 0, 2, 1'b0);
    chk("t5_count3", bit_count, 3);
    frame_start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    frame_start = 1'b0; bit_valid = 1'b0;
    chk("t5_fs_count1", bit_count, 1);
    chk("t5_fs_no_ovf", overflow, 0);
    send_range(8'h96, 1'b1, 1, 7, 1'b0);
    chk("t5_valid", word_valid, 1);
    chk("t5_word_96", word_out, 8'h96);
    send_range(8'hC0, 1'b1, 0, 1, 1'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t5_fs_alone_count", bit_count, 0);
    chk("t5_fs_alone_busy", busy, 0);
    // frame_start on what would be the completing bit: no word emitted
    send_range(8'hFF, 1'b1, 0, 6, 1'b0);
    frame_start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    frame_start = 1'b0; bit_valid = 1'b0;
    chk("t5_fs_prio_valid", word_valid, 0);
    chk("t5_fs_prio_count", bit_count, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t5_realign", bit_count, 0);

    // 6: gaps, then reset mid-word
    send_range(8'hC3, 1'b1, 0, 7, 1'b1);
    chk("t6_valid", word_valid, 1);
    chk("t6_word_c3", word_out, 8'hC3);
    send_range(8'hFF, 1'b1, 0, 4, 1'b0);
    chk("t6_count5", bit_count, 5);
    rst_n = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    bit_valid = 1'b0; rst_n = 1'b1;
    chk("t6_rst_word", word_out, 8'h00);
    chk("t6_rst_valid", word_valid, 0);
    chk("t6_rst_count", bit_count, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ovf", overflow, 0);
    send_range(8'h5A, 1'b1, 0, 7, 1'b0);
    chk("t6_clean_valid", word_valid, 1);
    chk("t6_clean_word", word_out, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
